// File: rtl/exu_writeback_arbiter.sv
// Merges PORTS execution result streams into the single reorder-buffer writeback port.
// Each port has a small first-word-fall-through FIFO, and a round-robin arbiter drains them.
module exu_writeback_arbiter #(
    parameter int PORTS      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int PKT_W      = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic [PORTS*32-1:0]        result_i,
    input  logic [PORTS*PKT_W-1:0]     ipacket_i,
    input  logic [PORTS-1:0]           data_valid_i,
    input  logic                       wb_ready_i,
    output logic                       wb_valid_o,
    output logic [31:0]                wb_result_o,
    output logic [PKT_W-1:0]           wb_ipacket_o,
    output logic [$clog2(PORTS)-1:0]   wb_port_o,
    output logic                       stall_o,
    output logic                       empty_o,
    output logic                       overflow_o
);

    localparam int PORT_W  = $clog2(PORTS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 32 + PKT_W;

    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(PORTS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  STALL_CNT = CNT_W'(FIFO_DEPTH - 1);

    logic [PORTS-1:0]              not_empty;
    logic [PORTS-1:0]              nearly_full;
    logic [PORTS-1:0]              push_ok;
    logic [PORTS-1:0]              pop_sel;
    logic [PORTS-1:0][ENTRY_W-1:0] head_entry;

    logic [PORT_W-1:0] last_grant_reg;
    logic [PORT_W-1:0] lock_port_reg;
    logic              lock_reg;
    logic              overflow_reg;

    logic [PORT_W-1:0]  rr_port;
    logic [PORT_W-1:0]  hi_port;
    logic [PORT_W-1:0]  lo_port;
    logic               hi_found;
    logic [PORT_W-1:0]  grant_port;
    logic               pop;
    logic [ENTRY_W-1:0] wb_entry;

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_fifo
            logic [ENTRY_W-1:0] mem_reg [FIFO_DEPTH];
            logic [PTR_W-1:0]   rd_ptr_reg;
            logic [PTR_W-1:0]   wr_ptr_reg;
            logic [CNT_W-1:0]   count_reg;
            logic               full;

            assign full            = (count_reg == FULL_CNT);
            assign not_empty[gi]   = (count_reg != '0);
            assign nearly_full[gi] = (count_reg >= STALL_CNT);
            assign pop_sel[gi]     = pop && (grant_port == PORT_W'(gi));
            // A full FIFO still accepts a push when its head leaves in the same cycle.
            assign push_ok[gi]     = data_valid_i[gi] && (!full || pop_sel[gi]);
            assign head_entry[gi]  = mem_reg[rd_ptr_reg];

            always_ff @(posedge clk_i) begin
                if (push_ok[gi] && !flush_i) begin
                    mem_reg[wr_ptr_reg] <= {result_i[gi*32 +: 32], ipacket_i[gi*PKT_W +: PKT_W]};
                end
            end

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (flush_i) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push_ok[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop_sel[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    case ({push_ok[gi], pop_sel[gi]})
                        2'b10:   count_reg <= count_reg + CNT_W'(1);
                        2'b01:   count_reg <= count_reg - CNT_W'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Round-robin: lowest non-empty port above last_grant wins, else lowest at or below it.
    always_comb begin
        hi_found = 1'b0;
        hi_port  = '0;
        lo_port  = '0;
        for (int j = PORTS - 1; j >= 0; j--) begin
            if (not_empty[j]) begin
                if (PORT_W'(j) > last_grant_reg) begin
                    hi_found = 1'b1;
                    hi_port  = PORT_W'(j);
                end else begin
                    lo_port = PORT_W'(j);
                end
            end
        end
        rr_port = hi_found ? hi_port : lo_port;
    end

    assign grant_port = lock_reg ? lock_port_reg : rr_port;
    assign wb_valid_o = |not_empty;
    assign pop        = wb_valid_o && wb_ready_i;
    assign wb_entry   = head_entry[grant_port];

    assign wb_result_o  = wb_valid_o ? wb_entry[ENTRY_W-1 -: 32] : '0;
    assign wb_ipacket_o = wb_valid_o ? wb_entry[PKT_W-1:0] : '0;
    assign wb_port_o    = wb_valid_o ? grant_port : '0;

    assign stall_o    = |nearly_full;
    assign empty_o    = ~|not_empty;
    assign overflow_o = overflow_reg;

    // The lock freezes a presented entry until the reorder buffer takes it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant_reg <= LAST_PORT;
            lock_reg       <= 1'b0;
            lock_port_reg  <= '0;
            overflow_reg   <= 1'b0;
        end else if (flush_i) begin
            last_grant_reg <= LAST_PORT;
            lock_reg       <= 1'b0;
            lock_port_reg  <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            if (pop) begin
                last_grant_reg <= grant_port;
                lock_reg       <= 1'b0;
            end else if (wb_valid_o) begin
                lock_reg      <= 1'b1;
                lock_port_reg <= grant_port;
            end
            if (|(data_valid_i & ~push_ok)) begin
                overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exu_writeback_arbiter.sv
// Bench for exu_writeback_arbiter: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_exu_writeback_arbiter;

    localparam int PORTS = 3;
    localparam int DEPTH = 4;
    localparam int PKT_W = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush = 1'b0;
    logic                   wb_ready = 1'b0;
    logic [PORTS*32-1:0]    result = '0;
    logic [PORTS*PKT_W-1:0] ipacket = '0;
    logic [PORTS-1:0]       data_valid = '0;

    logic                   wb_valid;
    logic [31:0]            wb_result;
    logic [PKT_W-1:0]       wb_ipacket;
    logic [1:0]             wb_port;
    logic                   stall;
    logic                   empty;
    logic                   overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exu_writeback_arbiter #(.PORTS(PORTS), .FIFO_DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .flush_i      (flush),
        .result_i     (result),
        .ipacket_i    (ipacket),
        .data_valid_i (data_valid),
        .wb_ready_i   (wb_ready),
        .wb_valid_o   (wb_valid),
        .wb_result_o  (wb_result),
        .wb_ipacket_o (wb_ipacket),
        .wb_port_o    (wb_port),
        .stall_o      (stall),
        .empty_o      (empty),
        .overflow_o   (overflow)
    );

    // Reference model: one queue of results per port, plus arbitration bookkeeping.
    logic [31:0] mq [PORTS][$];
    int          m_last = PORTS - 1;
    int          m_hold = -1;
    bit          m_ovf  = 1'b0;

    function automatic logic [31:0] pkt_of(input logic [31:0] r);
        return r ^ 32'hFFFF_0000;
    endfunction

    function automatic int m_grant();
        if (m_hold >= 0) return m_hold;
        for (int k = 1; k <= PORTS; k++) begin
            int p;
            p = (m_last + k) % PORTS;
            if (mq[p].size() > 0) return p;
        end
        return -1;
    endfunction

    function automatic bit m_stall();
        for (int p = 0; p < PORTS; p++) if (mq[p].size() >= DEPTH - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < PORTS; p++) mq[p].delete();
        m_last = PORTS - 1;
        m_hold = -1;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step();
        int g;
        int pre_size [PORTS];
        bit do_pop;
        if (!rst_n) return;
        if (flush) begin
            model_reset();
            return;
        end
        g = m_grant();
        do_pop = (g >= 0) && wb_ready;
        for (int p = 0; p < PORTS; p++) pre_size[p] = mq[p].size();
        if (do_pop) begin
            void'(mq[g].pop_front());
            m_last = g;
            m_hold = -1;
        end else if (g >= 0) begin
            m_hold = g;
        end
        for (int p = 0; p < PORTS; p++) begin
            if (data_valid[p]) begin
                if (pre_size[p] < DEPTH || (do_pop && g == p)) mq[p].push_back(result[p*32 +: 32]);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs depend only on registered state, so check mid-cycle.
    always @(negedge clk) begin
        int          g;
        logic [31:0] e_res;
        logic [31:0] e_pkt;
        int          e_port;
        if (rst_n) begin
            g = m_grant();
            e_res = '0;
            e_pkt = '0;
            e_port = 0;
            if (g >= 0) begin
                e_res  = mq[g][0];
                e_pkt  = pkt_of(mq[g][0]);
                e_port = g;
            end
            chk("model_valid",    32'(wb_valid), 32'(g >= 0));
            chk("model_result",   wb_result, e_res);
            chk("model_ipacket",  wb_ipacket, e_pkt);
            chk("model_port",     32'(wb_port), e_port);
            chk("model_stall",    32'(stall), 32'(m_stall()));
            chk("model_empty",    32'(empty), 32'(g < 0));
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // One clock cycle: apply inputs, let the edge happen, return at the next falling edge.
    task automatic cyc(input logic [2:0] v, input logic [31:0] r0, input logic [31:0] r1,
                       input logic [31:0] r2, input logic rdy, input logic fl);
        data_valid = v;
        result     = {r2, r1, r0};
        ipacket    = {pkt_of(r2), pkt_of(r1), pkt_of(r0)};
        wb_ready   = rdy;
        flush      = fl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        $display("cycle t=%0t valid=%b port=%0d result=%h stall=%b empty=%b ovf=%b",
                 $time, wb_valid, wb_port, wb_result, stall, empty, overflow);
    endtask

    task automatic idle(input logic rdy);
        cyc(3'b000, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_valid", 32'(wb_valid), 32'h0);
        chk("reset_result", wb_result, 32'h0);
        chk("reset_port", 32'(wb_port), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_empty", 32'(empty), 32'h1);
        chk("reset_overflow", 32'(overflow), 32'h0);

        // Single push on port 1 appears next cycle, then drains.
        cyc(3'b010, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
        chk("t1_valid", 32'(wb_valid), 32'h1);
        chk("t1_port", 32'(wb_port), 32'h1);
        chk("t1_result", wb_result, 32'hDEAD_BEEF);
        chk("t1_ipacket", wb_ipacket, 32'h2152_BEEF);
        idle(1'b1);
        chk("t1_drained_valid", 32'(wb_valid), 32'h0);
        chk("t1_drained_empty", 32'(empty), 32'h1);

        // Simultaneous pushes after a flush drain in port order.
        cyc(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        cyc(3'b111, 32'hA, 32'hB, 32'hC, 1'b1, 1'b0);
        chk("t2_first", wb_result, 32'hA);
        idle(1'b1);
        chk("t2_second", wb_result, 32'hB);
        idle(1'b1);
        chk("t2_third", wb_result, 32'hC);
        idle(1'b1);
        chk("t2_empty", 32'(empty), 32'h1);
        // last_grant is now 2, so port 0 beats port 2.
        cyc(3'b101, 32'h10, 32'h0, 32'h30, 1'b1, 1'b0);
        chk("t2_rr_port", 32'(wb_port), 32'h0);
        idle(1'b1);
        chk("t2_rr_next", 32'(wb_port), 32'h2);
        idle(1'b1);

        // Grant lock holds port 2 while port 0 becomes eligible.
        cyc(3'b100, 32'h0, 32'h0, 32'h22, 1'b0, 1'b0);
        chk("t3_hold_a", wb_result, 32'h22);
        cyc(3'b001, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("t3_hold_port", 32'(wb_port), 32'h2);
        chk("t3_hold_b", wb_result, 32'h22);
        idle(1'b0);
        chk("t3_hold_c", wb_result, 32'h22);
        idle(1'b1);
        chk("t3_after_port", 32'(wb_port), 32'h0);
        chk("t3_after_result", wb_result, 32'h11);
        idle(1'b1);

        // Overfill port 0: stall from count 3, fifth push dropped.
        for (int i = 1; i <= 5; i++) begin
            cyc(3'b001, 32'(i), 32'h0, 32'h0, 1'b0, 1'b0);
            chk("t4_stall", 32'(stall), 32'(i >= 3));
            chk("t4_overflow", 32'(overflow), 32'(i == 5));
        end
        chk("t4_head", wb_result, 32'h1);
        for (int i = 2; i <= 4; i++) begin
            idle(1'b1);
            chk("t4_drain", wb_result, 32'(i));
        end
        idle(1'b1);
        chk("t4_empty", 32'(empty), 32'h1);
        chk("t4_sticky", 32'(overflow), 32'h1);

        // Full port 1 popped and pushed in the same cycle.
        cyc(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("t5_flush_ovf", 32'(overflow), 32'h0);
        for (int i = 1; i <= 4; i++) cyc(3'b010, 32'h0, 32'h70 + 32'(i), 32'h0, 1'b0, 1'b0);
        cyc(3'b010, 32'h0, 32'h77, 32'h0, 1'b1, 1'b0);
        chk("t5_no_ovf", 32'(overflow), 32'h0);
        chk("t5_stall", 32'(stall), 32'h1);
        chk("t5_head", wb_result, 32'h72);
        idle(1'b1);
        chk("t5_d1", wb_result, 32'h73);
        idle(1'b1);
        chk("t5_d2", wb_result, 32'h74);
        idle(1'b1);
        chk("t5_last", wb_result, 32'h77);
        idle(1'b1);

        // Flush with two loaded FIFOs and a concurrent push.
        cyc(3'b101, 32'h60, 32'h0, 32'h80, 1'b0, 1'b0);
        cyc(3'b101, 32'h61, 32'h0, 32'h81, 1'b0, 1'b0);
        for (int i = 2; i <= 4; i++) cyc(3'b100, 32'h0, 32'h0, 32'h80 + 32'(i), 1'b0, 1'b0);
        chk("t6_pre_ovf", 32'(overflow), 32'h1);
        chk("t6_pre_stall", 32'(stall), 32'h1);
        cyc(3'b001, 32'h99, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("t6_empty", 32'(empty), 32'h1);
        chk("t6_valid", 32'(wb_valid), 32'h0);
        chk("t6_ovf", 32'(overflow), 32'h0);
        chk("t6_stall", 32'(stall), 32'h0);
        idle(1'b1);
        chk("t6_no_ghost", 32'(wb_valid), 32'h0);

        // Sustained traffic on all ports: grants rotate 0,1,2.
        for (int k = 0; k < 6; k++) begin
            cyc(3'b111, 32'h100 + 32'(k), 32'h200 + 32'(k), 32'h300 + 32'(k), 1'b1, 1'b0);
            chk("t7_fair_port", 32'(wb_port), 32'(k % 3));
        end
        repeat (14) idle(1'b1);
        chk("t7_drained", 32'(empty), 32'h1);

        // Asynchronous reset mid-operation.
        cyc(3'b001, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("t8_loaded", 32'(wb_valid), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t8_async_valid", 32'(wb_valid), 32'h0);
        chk("t8_async_empty", 32'(empty), 32'h1);
        model_reset();
        data_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3'b100, 32'h0, 32'h0, 32'h66, 1'b1, 1'b0);
        chk("t8_after_port", 32'(wb_port), 32'h2);
        chk("t8_after_result", wb_result, 32'h66);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
